conv_window_sequencer: RTL and testbench

Parametrised successor to the single-map convolution controller. It walks a KxK kernel window with configurable stride over an IN_W x IN_H input image, once per output channel. It issues pixel and weight addresses to the MAC processing unit over a valid/ready handshake, waits for each window's result, then emits an output-buffer write strobe with the output address. It sits between the image/weight ROMs, the MAC PU and the feature-map output buffer.

---
 rtl/conv_window_sequencer.sv | 167 ++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Convolution window sequencer: walks a KxK window with stride over an IN_W x IN_H
// image for each output channel, feeding tap addresses to the MAC PU and strobing results out.
module conv_window_sequencer #(
  parameter int IN_W   = 28,
  parameter int IN_H   = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int NUM_OC = 1,
  parameter int PIX_AW = 10,
  parameter int WGT_AW = 4,
  parameter int OUT_AW = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mac_ready,
  input  logic              pu_done,
  output logic [PIX_AW-1:0] pixel_addr,
  output logic [WGT_AW-1:0] weight_addr,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic              out_wr_en,
  output logic [OUT_AW-1:0] out_addr,
  output logic              busy,
  output logic              final_done
);
  localparam int OUT_W = (IN_W - K) / STRIDE + 1;
  localparam int OUT_H = (IN_H - K) / STRIDE + 1;
  localparam int KW    = $clog2(K + 1);
  localparam int CW    = $clog2(OUT_W + 1);
  localparam int RW    = $clog2(OUT_H + 1);
  localparam int OCW   = $clog2(NUM_OC + 1);
  localparam logic [PIX_AW-1:0] COL_STEP = PIX_AW'(STRIDE);
  localparam logic [PIX_AW-1:0] ROW_STEP = PIX_AW'(STRIDE * IN_W);
  localparam logic [PIX_AW-1:0] LINE     = PIX_AW'(IN_W);
  localparam logic [WGT_AW-1:0] TAP_CNT  = WGT_AW'(K * K);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RES, S_WRITE, S_DONE} state_t;
  state_t r_state, w_next;

  logic [KW-1:0]     r_kc, r_kr;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [OCW-1:0]    r_oc;
  logic [PIX_AW-1:0] r_row_base, r_win_base, r_krow_off, r_pix;
  logic [WGT_AW-1:0] r_wgt_base, r_wgt;
  logic [OUT_AW-1:0] r_out;

  logic              w_xfer, w_tap_last, w_col_last, w_row_last, w_layer_last;
  logic [PIX_AW-1:0] w_row_base_nxt, w_win_base_nxt;
  logic [WGT_AW-1:0] w_wgt_base_nxt;

  assign w_xfer       = (r_state == S_ISSUE) && mac_ready;
  assign w_tap_last   = (r_kc == KW'(K - 1)) && (r_kr == KW'(K - 1));
  assign w_col_last   = (r_col == CW'(OUT_W - 1));
  assign w_row_last   = (r_row == RW'(OUT_H - 1));
  assign w_layer_last = w_col_last && w_row_last && (r_oc == OCW'(NUM_OC - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_ISSUE;
      S_ISSUE:    if (w_xfer && w_tap_last) w_next = S_WAIT_RES;
      S_WAIT_RES: if (pu_done) w_next = S_WRITE;
      S_WRITE:    w_next = w_layer_last ? S_DONE : S_ISSUE;
      S_DONE:     if (!start) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Base of the next window; all address state moves by constant steps only.
  always_comb begin
    w_row_base_nxt = r_row_base;
    w_win_base_nxt = r_win_base + COL_STEP;
    w_wgt_base_nxt = r_wgt_base;
    if (w_col_last) begin
      if (w_row_last) begin
        w_row_base_nxt = '0;
        w_win_base_nxt = '0;
        w_wgt_base_nxt = r_wgt_base + TAP_CNT;
      end else begin
        w_row_base_nxt = r_row_base + ROW_STEP;
        w_win_base_nxt = r_row_base + ROW_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_kc       <= '0;
      r_kr       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_oc       <= '0;
      r_row_base <= '0;
      r_win_base <= '0;
      r_krow_off <= '0;
      r_pix      <= '0;
      r_wgt_base <= '0;
      r_wgt      <= '0;
      r_out      <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_IDLE) begin
        r_kc       <= '0;
        r_kr       <= '0;
        r_col      <= '0;
        r_row      <= '0;
        r_oc       <= '0;
        r_row_base <= '0;
        r_win_base <= '0;
        r_krow_off <= '0;
        r_pix      <= '0;
        r_wgt_base <= '0;
        r_wgt      <= '0;
        r_out      <= '0;
      end else if (w_xfer && !w_tap_last) begin
        r_wgt <= r_wgt + WGT_AW'(1);
        if (r_kc == KW'(K - 1)) begin
          r_kc       <= '0;
          r_kr       <= r_kr + KW'(1);
          r_krow_off <= r_krow_off + LINE;
          r_pix      <= r_win_base + r_krow_off + LINE;
        end else begin
          r_kc  <= r_kc + KW'(1);
          r_pix <= r_pix + PIX_AW'(1);
        end
      end else if (r_state == S_WRITE) begin
        // Output order (col, row, oc) makes out_addr a plain running count.
        r_out      <= r_out + OUT_AW'(1);
        r_kc       <= '0;
        r_kr       <= '0;
        r_krow_off <= '0;
        r_row_base <= w_row_base_nxt;
        r_win_base <= w_win_base_nxt;
        r_wgt_base <= w_wgt_base_nxt;
        r_pix      <= w_win_base_nxt;
        r_wgt      <= w_wgt_base_nxt;
        if (w_col_last) begin
          r_col <= '0;
          if (w_row_last) begin
            r_row <= '0;
            r_oc  <= r_oc + OCW'(1);
          end else begin
            r_row <= r_row + RW'(1);
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign pixel_addr  = r_pix;
  assign weight_addr = r_wgt;
  assign mac_valid   = (r_state == S_ISSUE);
  assign mac_first   = mac_valid && (r_kc == '0) && (r_kr == '0);
  assign mac_last    = mac_valid && w_tap_last;
  assign out_wr_en   = (r_state == S_WRITE);
  assign out_addr    = r_out;
  assign busy        = (r_state == S_ISSUE) || (r_state == S_WAIT_RES) || (r_state == S_WRITE);
  assign final_done  = (r_state == S_DONE);
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: a 28x28/K3/S1 instance (A) and a 7x7/K3/S2/2-channel
// instance (B), each with a PU responder, a scoreboard of expected taps/writes and a monitor.
module tb_conv_window_sequencer;
  typedef struct {int pix; int wgt; bit first; bit last;} tap_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       a_start, a_abort, a_mac_ready, a_pu_done;
  logic [9:0] a_pixel_addr;
  logic [3:0] a_weight_addr;
  logic       a_mac_valid, a_mac_first, a_mac_last, a_out_wr_en, a_busy, a_final_done;
  logic [9:0] a_out_addr;

  logic       b_start, b_abort, b_mac_ready, b_pu_done;
  logic [5:0] b_pixel_addr;
  logic [4:0] b_weight_addr;
  logic       b_mac_valid, b_mac_first, b_mac_last, b_out_wr_en, b_busy, b_final_done;
  logic [4:0] b_out_addr;

  conv_window_sequencer u_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort),
    .mac_ready(a_mac_ready), .pu_done(a_pu_done), .pixel_addr(a_pixel_addr),
    .weight_addr(a_weight_addr), .mac_valid(a_mac_valid), .mac_first(a_mac_first),
    .mac_last(a_mac_last), .out_wr_en(a_out_wr_en), .out_addr(a_out_addr),
    .busy(a_busy), .final_done(a_final_done));

  conv_window_sequencer #(
    .IN_W(7), .IN_H(7), .K(3), .STRIDE(2), .NUM_OC(2),
    .PIX_AW(6), .WGT_AW(5), .OUT_AW(5)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
    .mac_ready(b_mac_ready), .pu_done(b_pu_done), .pixel_addr(b_pixel_addr),
    .weight_addr(b_weight_addr), .mac_valid(b_mac_valid), .mac_first(b_mac_first),
    .mac_last(b_mac_last), .out_wr_en(b_out_wr_en), .out_addr(b_out_addr),
    .busy(b_busy), .final_done(b_final_done));

  int   checks = 0;
  int   failures = 0;
  tap_t qa[$], qb[$];
  int   qwa[$], qwb[$];

  int   a_lat = 2, b_lat = 2;
  bit   a_stall = 0, b_stall = 0, b_spur = 0;
  int   a_ntaps, a_wtaps, a_nwr, a_last_pix;
  int   b_ntaps, b_wtaps, b_nwr, b_wr_tot;
  int   b_win1[9];
  int   exp_w1[9] = '{2, 3, 4, 9, 10, 11, 16, 17, 18};

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Expected traffic from the direct loop formulas; taps beyond max_taps are dropped
  // and a write is only expected for windows whose taps all fit.
  task automatic push_layer(input bit sel, input int iw, input int ih, input int k,
                            input int s, input int noc, input int max_taps);
    int ow, oh, n;
    tap_t t;
    ow = (iw - k) / s + 1;
    oh = (ih - k) / s + 1;
    n  = 0;
    for (int oc = 0; oc < noc; oc++)
      for (int row = 0; row < oh; row++)
        for (int col = 0; col < ow; col++) begin
          for (int kr = 0; kr < k; kr++)
            for (int kc = 0; kc < k; kc++) begin
              if (n < max_taps) begin
                t.pix   = (row * s + kr) * iw + col * s + kc;
                t.wgt   = oc * k * k + kr * k + kc;
                t.first = (kr == 0) && (kc == 0);
                t.last  = (kr == k - 1) && (kc == k - 1);
                if (sel) qb.push_back(t); else qa.push_back(t);
              end
              n++;
            end
          if (n <= max_taps) begin
            if (sel) qwb.push_back(oc * ow * oh + row * ow + col);
            else     qwa.push_back(oc * ow * oh + row * ow + col);
          end
        end
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk); #2;
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #2;
    if (sel) b_start = 1'b0; else a_start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int bound, input string nm);
    int n;
    n = 0;
    while (!(sel ? b_final_done : a_final_done) && n < bound) begin
      @(posedge clk); #2;
      n++;
    end
    chk(nm, sel ? b_final_done : a_final_done, 1);
  endtask

  // PU responders: pu_done lat cycles after the last tap transfers, optional stalls.
  bit a_xl;
  int a_cnt = 0;
  initial begin
    a_mac_ready = 1'b1;
    a_pu_done   = 1'b0;
    forever begin
      @(negedge clk);
      a_xl = a_mac_valid && a_mac_ready && a_mac_last;
      @(posedge clk); #1;
      a_pu_done = 1'b0;
      if (a_xl) a_cnt = a_lat;
      else if (a_cnt > 0) begin
        a_cnt--;
        if (a_cnt == 0) a_pu_done = 1'b1;
      end
      a_mac_ready = a_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  bit b_xl;
  int b_cnt = 0;
  initial begin
    b_mac_ready = 1'b1;
    b_pu_done   = 1'b0;
    forever begin
      @(negedge clk);
      b_xl = b_mac_valid && b_mac_ready && b_mac_last;
      @(posedge clk); #1;
      b_pu_done = 1'b0;
      if (b_xl) b_cnt = b_lat;
      else if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) b_pu_done = 1'b1;
      end
      // Stray pu_done while taps are still being issued must be ignored.
      if (b_spur && b_cnt == 0 && !b_pu_done && b_mac_valid && $urandom_range(0, 3) == 0)
        b_pu_done = 1'b1;
      b_mac_ready = b_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor A
  bit         a_pstall = 0, a_pfd = 0, a_pf, a_pl;
  logic [9:0] a_pp;
  logic [3:0] a_pw;
  tap_t       ta;
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (a_pstall) begin
        chk("a_stall_valid", a_mac_valid, 1);
        chk("a_stall_pix", a_pixel_addr, a_pp);
        chk("a_stall_wgt", a_weight_addr, a_pw);
        chk("a_stall_first", a_mac_first, a_pf);
        chk("a_stall_last", a_mac_last, a_pl);
      end
      if (a_mac_valid && a_mac_ready) begin
        if (qa.size() == 0) chk("a_tap_unexpected", qa.size(), 1);
        else begin
          ta = qa.pop_front();
          chk("a_pix", a_pixel_addr, ta.pix);
          chk("a_wgt", a_weight_addr, ta.wgt);
          chk("a_first", a_mac_first, ta.first);
          chk("a_last", a_mac_last, ta.last);
        end
        a_ntaps++;
        a_wtaps++;
        a_last_pix = a_pixel_addr;
      end
      if (a_out_wr_en) begin
        if (qwa.size() == 0) chk("a_wr_unexpected", qwa.size(), 1);
        else chk("a_out_addr", a_out_addr, qwa.pop_front());
        chk("a_taps_per_win", a_wtaps, 9);
        chk("a_wr_while_done", a_final_done, 0);
        a_wtaps = 0;
        a_nwr++;
      end
      if (a_final_done && !a_pfd) begin
        chk("a_done_taps_left", qa.size(), 0);
        chk("a_done_wr_left", qwa.size(), 0);
      end
      if (!a_busy && !a_final_done) begin
        a_ntaps = 0;
        a_wtaps = 0;
        a_nwr   = 0;
      end
    end
    a_pstall = a_mac_valid && !a_mac_ready;
    a_pp = a_pixel_addr; a_pw = a_weight_addr; a_pf = a_mac_first; a_pl = a_mac_last;
    a_pfd = a_final_done;
  end

  // Monitor B
  bit         b_pstall = 0, b_pfd = 0, b_pf, b_pl;
  logic [5:0] b_pp;
  logic [4:0] b_pw;
  tap_t       tb_t;
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (b_pstall) begin
        chk("b_stall_valid", b_mac_valid, 1);
        chk("b_stall_pix", b_pixel_addr, b_pp);
        chk("b_stall_wgt", b_weight_addr, b_pw);
        chk("b_stall_first", b_mac_first, b_pf);
        chk("b_stall_last", b_mac_last, b_pl);
      end
      if (b_mac_valid && b_mac_ready) begin
        if (qb.size() == 0) chk("b_tap_unexpected", qb.size(), 1);
        else begin
          tb_t = qb.pop_front();
          chk("b_pix", b_pixel_addr, tb_t.pix);
          chk("b_wgt", b_weight_addr, tb_t.wgt);
          chk("b_first", b_mac_first, tb_t.first);
          chk("b_last", b_mac_last, tb_t.last);
        end
        if (b_ntaps >= 9 && b_ntaps < 18) b_win1[b_ntaps-9] = b_pixel_addr;
        b_ntaps++;
        b_wtaps++;
      end
      if (b_out_wr_en) begin
        if (qwb.size() == 0) chk("b_wr_unexpected", qwb.size(), 1);
        else chk("b_out_addr", b_out_addr, qwb.pop_front());
        chk("b_taps_per_win", b_wtaps, 9);
        chk("b_wr_while_done", b_final_done, 0);
        b_wtaps = 0;
        b_nwr++;
        b_wr_tot++;
      end
      if (b_final_done && !b_pfd) begin
        chk("b_done_taps_left", qb.size(), 0);
        chk("b_done_wr_left", qwb.size(), 0);
      end
      if (!b_busy && !b_final_done) begin
        b_ntaps = 0;
        b_wtaps = 0;
        b_nwr   = 0;
      end
    end
    b_pstall = b_mac_valid && !b_mac_ready;
    b_pp = b_pixel_addr; b_pw = b_weight_addr; b_pf = b_mac_first; b_pl = b_mac_last;
    b_pfd = b_final_done;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  localparam int ALL = 1 << 30;
  int n, acc, tot0;

  initial begin
    reset_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0;
    b_start = 1'b0; b_abort = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_valid", a_mac_valid, 0);
    chk("rst_a_wr", a_out_wr_en, 0);
    chk("rst_a_done", a_final_done, 0);
    chk("rst_a_pix", a_pixel_addr, 0);
    chk("rst_a_oaddr", a_out_addr, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_first", b_mac_first, 0);
    chk("rst_b_wgt", b_weight_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full default layer: 676 windows, pu_done 2 cycles after the last tap.
    push_layer(0, 28, 28, 3, 1, 1, ALL);
    pulse_start(0);
    wait_done(0, 20000, "a_full_done");
    chk("a_final_last_pix", a_last_pix, 783);
    chk("a_write_count", a_nwr, 676);
    @(posedge clk); #2;
    chk("a_done_to_idle", a_final_done, 0);

    // Stride 2, two output channels.
    push_layer(1, 7, 7, 3, 2, 2, ALL);
    pulse_start(1);
    wait_done(1, 2000, "b_s2_done");
    for (int i = 0; i < 9; i++) chk("b_win1_pix", b_win1[i], exp_w1[i]);
    chk("b_s2_writes", b_nwr, 18);
    @(posedge clk); #2;

    // Random mac_ready stalls.
    b_stall = 1'b1; b_lat = 1;
    push_layer(1, 7, 7, 3, 2, 2, ALL);
    pulse_start(1);
    wait_done(1, 5000, "b_stall_done");
    chk("b_stall_writes", b_nwr, 18);
    b_stall = 1'b0;
    @(posedge clk); #2;

    // Slow PU with stray pu_done pulses during tap issue.
    b_lat = 20; b_spur = 1'b1;
    push_layer(1, 7, 7, 3, 2, 2, ALL);
    pulse_start(1);
    wait_done(1, 5000, "b_slow_done");
    chk("b_slow_writes", b_nwr, 18);
    b_lat = 2; b_spur = 1'b0;
    @(posedge clk); #2;

    // Abort while window 5 presents tap 4.
    push_layer(1, 7, 7, 3, 2, 2, 50);
    pulse_start(1);
    n = 0;
    while (!(b_nwr == 5 && b_mac_valid && b_weight_addr == 5'd4) && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("b_abort_reached", b_weight_addr, 4);
    tot0 = b_wr_tot;
    b_abort = 1'b1;
    @(posedge clk); #2;
    b_abort = 1'b0;
    chk("b_abort_busy", b_busy, 0);
    chk("b_abort_valid", b_mac_valid, 0);
    acc = 0;
    repeat (30) begin
      @(posedge clk); #2;
      acc += b_final_done;
    end
    chk("b_abort_no_done", acc, 0);
    chk("b_abort_no_write", b_wr_tot - tot0, 0);
    chk("b_abort_taps_used", qb.size(), 0);
    chk("b_abort_wr_used", qwb.size(), 0);
    push_layer(1, 7, 7, 3, 2, 2, ALL);
    pulse_start(1);
    wait_done(1, 2000, "b_restart_done");
    chk("b_restart_writes", b_nwr, 18);
    @(posedge clk); #2;

    // start held through the run, toggled mid-run, then held in DONE.
    push_layer(1, 7, 7, 3, 2, 2, ALL);
    @(posedge clk); #2;
    b_start = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    b_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    b_start = 1'b1;
    wait_done(1, 2000, "b_held_done");
    chk("b_held_writes", b_nwr, 18);
    acc = 0;
    repeat (5) begin
      @(posedge clk); #2;
      acc += b_final_done;
    end
    chk("b_done_held", acc, 5);
    b_start = 1'b0;
    @(posedge clk); #2;
    chk("b_done_release", b_final_done, 0);
    acc = 0;
    repeat (4) begin
      @(posedge clk); #2;
      acc += b_busy;
    end
    chk("b_stays_idle", acc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
